// File: rtl/polar_to_cart_if.sv
// Stream, lookup and result signals of polar_to_cart, grouped as one bundle.
// The slave modport is the converter; the master modport is its environment.
interface polar_to_cart_if;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] radius_in;
    logic [15:0] angle_in;
    logic [15:0] lut_angle_out;
    logic [15:0] lut_cos_abs_in;
    logic [15:0] lut_sin_abs_in;
    logic        lut_cos_sign_in;
    logic        lut_sin_sign_in;
    logic        valid_out;
    logic        ready_in;
    logic [16:0] x_out;
    logic [16:0] y_out;
    logic        err_out;

    modport slave (
        input  valid_in, radius_in, angle_in,
        input  lut_cos_abs_in, lut_sin_abs_in, lut_cos_sign_in, lut_sin_sign_in,
        input  ready_in,
        output ready_out, lut_angle_out, valid_out, x_out, y_out, err_out
    );

    modport master (
        output valid_in, radius_in, angle_in,
        output lut_cos_abs_in, lut_sin_abs_in, lut_cos_sign_in, lut_sin_sign_in,
        output ready_in,
        input  ready_out, lut_angle_out, valid_out, x_out, y_out, err_out
    );
endinterface

// File: rtl/polar_to_cart.sv
// Polar (radius, whole-degree angle) to cartesian converter using an external cos/sin lookup.
// Non-stalling pipeline feeding an output FIFO; admission is limited by FIFO space plus samples in flight.
module polar_to_cart #(
    parameter int LUT_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input logic            clk_in,
    input logic            rst_n_in,
    polar_to_cart_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // S0 capture
    logic [15:0] radius_q;
    logic [15:0] angle_q;
    logic        s0_valid_q;
    logic        err_q;
    logic        rdy_en_q;

    // Lookup-latency delay line: signs are taken while the address is on lut_angle_out
    logic [LUT_LATENCY-1:0] dly_valid_q;
    logic [LUT_LATENCY-1:0] dly_cos_sign_q;
    logic [LUT_LATENCY-1:0] dly_sin_sign_q;
    logic [15:0]            dly_radius_q [LUT_LATENCY];

    // Multiply stage
    logic        mul_valid_q;
    logic        mul_cos_sign_q;
    logic        mul_sin_sign_q;
    logic [31:0] prod_x_q;
    logic [31:0] prod_y_q;

    // Output FIFO
    logic [16:0]   fifo_x_q [FIFO_DEPTH];
    logic [16:0]   fifo_y_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] fifo_count_q;
    logic [CW-1:0] fifo_count_d;
    logic [CW-1:0] in_flight_q;
    logic [CW-1:0] in_flight_d;

    logic [CW:0]   occupancy;
    logic          ready;
    logic          accept;
    logic          illegal_angle;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic [16:0]   mag_x;
    logic [16:0]   mag_y;
    logic [16:0]   res_x;
    logic [16:0]   res_y;
    logic          unused_prod_bits;

    assign occupancy     = {1'b0, fifo_count_q} + {1'b0, in_flight_q};
    assign ready         = rdy_en_q && (occupancy < DEPTH_W);
    assign accept        = bus.valid_in && ready;
    assign illegal_angle = bus.angle_in >= 16'd360;
    assign fifo_nonempty = fifo_count_q != '0;
    assign push          = mul_valid_q;
    assign pop           = fifo_nonempty && bus.ready_in;

    // Truncating Q1.15 scale; a zero magnitude negates to zero, so no negative zero can appear
    assign mag_x = prod_x_q[31:15];
    assign mag_y = prod_y_q[31:15];
    assign res_x = mul_cos_sign_q ? mag_x : (17'd0 - mag_x);
    assign res_y = mul_sin_sign_q ? mag_y : (17'd0 - mag_y);
    assign unused_prod_bits = ^{prod_x_q[14:0], prod_y_q[14:0]};

    always_comb begin
        fifo_count_d = fifo_count_q;
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CW'(1);
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - CW'(1);
        end
        in_flight_d = in_flight_q;
        if (accept && !push) begin
            in_flight_d = in_flight_q + CW'(1);
        end else if (!accept && push) begin
            in_flight_d = in_flight_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            radius_q       <= '0;
            angle_q        <= '0;
            s0_valid_q     <= 1'b0;
            err_q          <= 1'b0;
            rdy_en_q       <= 1'b0;
            dly_valid_q    <= '0;
            dly_cos_sign_q <= '0;
            dly_sin_sign_q <= '0;
            for (int k = 0; k < LUT_LATENCY; k++) begin
                dly_radius_q[k] <= '0;
            end
            mul_valid_q    <= 1'b0;
            mul_cos_sign_q <= 1'b0;
            mul_sin_sign_q <= 1'b0;
            prod_x_q       <= '0;
            prod_y_q       <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_x_q[k] <= '0;
                fifo_y_q[k] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_count_q   <= '0;
            in_flight_q    <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            s0_valid_q <= accept;
            err_q      <= accept && illegal_angle;
            if (accept) begin
                radius_q <= bus.radius_in;
                angle_q  <= illegal_angle ? 16'd0 : bus.angle_in;
            end

            dly_valid_q[0]    <= s0_valid_q;
            dly_cos_sign_q[0] <= bus.lut_cos_sign_in;
            dly_sin_sign_q[0] <= bus.lut_sin_sign_in;
            dly_radius_q[0]   <= radius_q;
            for (int k = 1; k < LUT_LATENCY; k++) begin
                dly_valid_q[k]    <= dly_valid_q[k-1];
                dly_cos_sign_q[k] <= dly_cos_sign_q[k-1];
                dly_sin_sign_q[k] <= dly_sin_sign_q[k-1];
                dly_radius_q[k]   <= dly_radius_q[k-1];
            end

            mul_valid_q    <= dly_valid_q[LUT_LATENCY-1];
            mul_cos_sign_q <= dly_cos_sign_q[LUT_LATENCY-1];
            mul_sin_sign_q <= dly_sin_sign_q[LUT_LATENCY-1];
            prod_x_q       <= 32'(dly_radius_q[LUT_LATENCY-1]) * 32'(bus.lut_cos_abs_in);
            prod_y_q       <= 32'(dly_radius_q[LUT_LATENCY-1]) * 32'(bus.lut_sin_abs_in);

            if (push) begin
                fifo_x_q[wr_ptr_q] <= res_x;
                fifo_y_q[wr_ptr_q] <= res_y;
                wr_ptr_q           <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fifo_count_q <= fifo_count_d;
            in_flight_q  <= in_flight_d;

            // Admission control makes these unreachable; they guard against a broken count
            assert (!(push && !pop && fifo_count_q == DEPTH_C));
            assert (!(push && in_flight_q == '0));
        end
    end

    assign bus.ready_out     = ready;
    assign bus.lut_angle_out = angle_q;
    assign bus.err_out       = err_q;
    assign bus.valid_out     = fifo_nonempty;
    assign bus.x_out         = fifo_nonempty ? fifo_x_q[rd_ptr_q] : 17'd0;
    assign bus.y_out         = fifo_nonempty ? fifo_y_q[rd_ptr_q] : 17'd0;
endmodule
